dds_rom_reader: RTL

DDS_ROM_READER -- requirements
Module: dds_rom_reader

---
 rtl/sine_pkg.sv | 19 +
 rtl/dds_rom_reader_tick_counter.sv | 39 +++
 rtl/dds_rom_reader.sv | 134 +++++++++++++
 3 files changed

// File: rtl/sine_pkg.sv
// rtl/sine_pkg.sv - shared state enum and default constants for the DDS ROM reader
package sine_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } dds_state_e;

    localparam int TICK_DIV_DEF = 1000;
    localparam int ACC_W_DEF    = 32;
    localparam int ADDR_W_DEF   = 6;
    localparam int DATA_W_DEF   = 32;

    // Reset tuning word is 1 << shift: one ROM address per tick.
    function automatic int ftw_reset_shift(input int acc_w, input int addr_w);
        return acc_w - addr_w;
    endfunction

endpackage

// File: rtl/dds_rom_reader_tick_counter.sv
// rtl/dds_rom_reader_tick_counter.sv - sample-tick divider, held at zero while not running
module tick_counter
    import sine_pkg::*;
#(
    parameter int DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !run || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear in the terminal cycle swallows the tick.
    assign tick = run && !clr && (cnt_q == LAST);

endmodule

// File: rtl/dds_rom_reader.sv
// rtl/dds_rom_reader.sv - phase-accumulator DDS driving an external synchronous sine ROM
module dds_rom_reader
    import sine_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter logic [ACC_W-1:0] FTW_RESET = ACC_W'(1) << ftw_reset_shift(ACC_W, ADDR_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sync_clr,
    input  logic [ACC_W-1:0]  ftw,
    input  logic              ftw_valid,
    output logic              ftw_ready,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              wrap
);

    logic rst_meta_q, rst_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    dds_state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable && rst_sync_q) state_d = ST_RUN;
            ST_RUN:  if (!enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    logic run, tick;
    assign run = (state_q == ST_RUN);

    tick_counter #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sync_clr),
        .run   (run),
        .tick  (tick)
    );

    logic [ACC_W-1:0]  acc_q, acc_d, ftw_active_q, ftw_active_d, slot_q, slot_d;
    logic              slot_full_q, slot_full_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_en_q, rom_en_d, wrap_q, wrap_d;
    logic [ACC_W:0]    sum;
    logic              accept;

    assign sum    = {1'b0, acc_q} + {1'b0, ftw_active_q};
    assign accept = ftw_valid && !slot_full_q;

    always_comb begin
        acc_d        = acc_q;
        ftw_active_d = ftw_active_q;
        slot_d       = slot_q;
        slot_full_d  = slot_full_q;
        rom_addr_d   = rom_addr_q;
        rom_en_d     = 1'b0;
        wrap_d       = 1'b0;
        if (accept) begin
            slot_d      = ftw;
            slot_full_d = 1'b1;
        end
        if (sync_clr) begin
            acc_d = '0;
        end else if (tick) begin
            // Address comes from the pre-add phase; a staged word takes effect on the next add.
            rom_addr_d = acc_q[ACC_W-1 -: ADDR_W];
            rom_en_d   = 1'b1;
            wrap_d     = sum[ACC_W];
            acc_d      = sum[ACC_W-1:0];
            if (slot_full_q) begin
                ftw_active_d = slot_q;
                slot_full_d  = 1'b0;
            end
        end
    end

    logic              cap_q;
    logic [DATA_W-1:0] sample_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            ftw_active_q <= FTW_RESET;
            slot_q       <= '0;
            slot_full_q  <= 1'b0;
            rom_addr_q   <= '0;
            rom_en_q     <= 1'b0;
            wrap_q       <= 1'b0;
            cap_q        <= 1'b0;
            sample_q     <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            ftw_active_q <= ftw_active_d;
            slot_q       <= slot_d;
            slot_full_q  <= slot_full_d;
            rom_addr_q   <= rom_addr_d;
            rom_en_q     <= rom_en_d;
            wrap_q       <= wrap_d;
            cap_q        <= rom_en_q;
            if (cap_q) sample_q <= rom_data;
        end
    end

    // The ROM word is presented during the capture cycle and then held.
    assign sample       = cap_q ? rom_data : sample_q;
    assign sample_valid = cap_q;
    assign ftw_ready    = !slot_full_q;
    assign rom_addr     = rom_addr_q;
    assign rom_en       = rom_en_q;
    assign wrap         = wrap_q;

endmodule
